// File: rtl/gate_sweep_engine.sv
// rtl/gate_sweep_engine.sv - self-sequencing exhaustive sweep of an N-input configurable gate
module gate_sweep_engine #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            pause,
    output logic [N_IN-1:0] vec_o,
    output logic            y_o,
    output logic            valid_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [N_IN:0]   ones_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_FIN   = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] CNT_LAST = '1;
    localparam logic [N_IN-1:0] CNT_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              y_q, y_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [N_IN:0]     ones_q, ones_d;
    logic              f_cur;

    // Gate function selected by the latched op; codes 6-7 never reach op_q.
    function automatic logic gate_f(input logic [2:0] sel, input logic [N_IN-1:0] v);
        logic r;
        case (sel)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ^v;
            3'd3:    r = ~&v;
            3'd4:    r = ~|v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign f_cur = gate_f(op_q, cnt_q);

    // Next-state and registered-output computation for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        vec_d   = vec_q;
        y_d     = y_q;
        ones_d  = ones_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op <= 3'd5) begin
                        op_d    = op;
                        cnt_d   = '0;
                        ones_d  = '0;
                        state_d = S_SWEEP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                if (!pause) begin
                    vec_d   = cnt_q;
                    y_d     = f_cur;
                    valid_d = 1'b1;
                    ones_d  = ones_q + {{N_IN{1'b0}}, f_cur};
                    cnt_d   = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset that abandons any sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            vec_q   <= '0;
            y_q     <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            vec_q   <= vec_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ones_q  <= ones_d;
        end
    end

    assign vec_o   = vec_q;
    assign y_o     = y_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign ones_o  = ones_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_gate_sweep_engine.sv
// tb/tb_gate_sweep_engine.sv - scoreboard bench for gate_sweep_engine
module tb_gate_sweep_engine;

    localparam int N  = 3;
    localparam int NV = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic         pause;
    logic [N-1:0] vec_o;
    logic         y_o;
    logic         valid_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [N:0]   ones_o;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        int vec;
        int y;
        int ones;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    exp_t mon_e;
    int   mon_d;
    int   last_ones = 0;

    gate_sweep_engine #(.N_IN(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .pause   (pause),
        .vec_o   (vec_o),
        .y_o     (y_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .ones_o  (ones_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference gate: defined from the truth of the named function, not from reductions.
    function automatic int ref_f(input int o, input int v);
        int c;
        c = $countones(v);
        case (o)
            0:       return (v == NV - 1) ? 1 : 0;
            1:       return (v != 0) ? 1 : 0;
            2:       return c % 2;
            3:       return (v == NV - 1) ? 0 : 1;
            4:       return (v == 0) ? 1 : 0;
            5:       return (c % 2 == 0) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic push_model(input int o);
        int ones;
        exp_t e;
        ones = 0;
        for (int v = 0; v < NV; v++) begin
            e.vec = v;
            e.y = ref_f(o, v);
            ones += e.y;
            e.ones = ones;
            exp_q.push_back(e);
        end
        done_q.push_back(ones);
        last_ones = ones;
    endtask

    // Monitor: pops expected pairs whenever the DUT presents a result or done pulse.
    always @(negedge clk) begin
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("vec", int'(vec_o), mon_e.vec);
                chk("y", int'(y_o), mon_e.y);
                chk("ones_run", int'(ones_o), mon_e.ones);
                chk("busy_on_valid", int'(busy_o), 1);
            end
        end
        if (done_o) begin
            if (done_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_d = done_q.pop_front();
                chk("done_ones", int'(ones_o), mon_d);
                chk("busy_on_done", int'(busy_o), 0);
                chk("valid_on_done", int'(valid_o), 0);
            end
        end
    end

    // Called #1 after a clock edge; mode 0 plain, 1 pause 3 cycles after vec 2, 2 random noise.
    task automatic do_sweep(input int o, input int mode);
        int emitted;
        int edges;
        int ptaken;
        int last_edge;
        int p;
        start = 1'b1;
        op = 3'(o);
        pause = 1'b0;
        push_model(o);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy_o), 1);
        emitted = 0;
        edges = 0;
        ptaken = 0;
        last_edge = 0;
        while (1) begin
            p = 0;
            if (mode == 1 && emitted == 3 && ptaken < 3) begin
                p = 1;
                ptaken++;
            end else if (mode == 2) begin
                p = ($urandom_range(0, 2) == 0) ? 1 : 0;
                start = $urandom_range(0, 3) == 0;
                op = 3'($urandom_range(0, 7));
            end
            pause = p[0];
            if (emitted < NV && p == 0) begin
                emitted++;
                if (emitted == NV) last_edge = edges + 1;
            end
            @(posedge clk);
            edges++;
            #1;
            if (done_o || edges > 200) break;
        end
        start = 1'b0;
        pause = 1'b0;
        chk("sweep_latency", edges, last_edge + 1);
        if (mode == 1) chk("pause_latency", edges, NV + 4);
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        start = 1'b0;
        op = 3'd0;
        pause = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_vec", int'(vec_o), 0);
        chk("rst_y", int'(y_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_ones", int'(ones_o), 0);

        @(posedge clk);
        #1;
        for (int o = 0; o < 6; o++) do_sweep(o, 0);
        do_sweep(1, 1);
        for (int i = 0; i < 6; i++) do_sweep($urandom_range(0, 5), 2);

        // Illegal op: error pulse, no sweep, result count untouched.
        @(posedge clk);
        #1;
        chk("ones_hold_idle", int'(ones_o), last_ones);
        start = 1'b1;
        op = 3'(6 + $urandom_range(0, 1));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_pulse", int'(err_o), 1);
        chk("err_busy", int'(busy_o), 0);
        chk("err_valid", int'(valid_o), 0);
        chk("err_ones", int'(ones_o), last_ones);
        do_sweep(5, 0);

        // Reset while vec 5 is on the output abandons the sweep.
        start = 1'b1;
        op = 3'($urandom_range(0, 5));
        push_model(int'(op));
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(valid_o && vec_o == 3'd5) && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("reach_vec5_timeout", guard < 50 ? 1 : 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        chk("mid_rst_vec", int'(vec_o), 0);
        chk("mid_rst_y", int'(y_o), 0);
        chk("mid_rst_valid", int'(valid_o), 0);
        chk("mid_rst_busy", int'(busy_o), 0);
        chk("mid_rst_done", int'(done_o), 0);
        chk("mid_rst_ones", int'(ones_o), 0);
        repeat (NV + 3) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(busy_o), 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
